// File: rtl/param_method_queue_if.sv
// ============================================================================
// param_method_queue_if : method-style ports (EN_/RDY_ + arguments) of the queue
// Rev 1.0
// ============================================================================
`default_nettype none

interface param_method_queue_if #(
  parameter int WIDTH = 11
);
  logic [WIDTH-1:0] start_sta_1;
  logic [WIDTH-1:0] start_stb_1;
  logic             EN_start;
  logic             RDY_start;
  logic [WIDTH-1:0] result_stc_1;
  logic [WIDTH-1:0] result;
  logic             RDY_result;
  logic [WIDTH-1:0] check_std_1;
  logic             EN_check;
  logic [WIDTH-1:0] check;
  logic             RDY_check;

  modport master (
    output start_sta_1, start_stb_1, EN_start, result_stc_1, check_std_1, EN_check,
    input  RDY_start, result, RDY_result, check, RDY_check
  );

  modport slave (
    input  start_sta_1, start_stb_1, EN_start, result_stc_1, check_std_1, EN_check,
    output RDY_start, result, RDY_result, check, RDY_check
  );
endinterface

`default_nettype wire

// File: rtl/param_method_queue.sv
// ============================================================================
// param_method_queue : DEPTH-entry operand queue with combine/accumulate methods
// Rev 1.0
// ============================================================================
`default_nettype none

module param_method_queue #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  wire logic             CLK,
  input  wire logic             RST_N,
  param_method_queue_if.slave   bus
);
  localparam int                c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL = DEPTH[c_AW:0];

  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_AW:0]      r_count;
  logic [WIDTH-1:0]   r_acc;

  logic               w_not_empty;
  logic               w_not_full;
  logic               w_do_start;
  logic               w_do_check;
  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_head_f;
  logic [WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]   w_check;

  function automatic logic [WIDTH-1:0] f_comb(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    if (MODE == 1) return x ^ y;
    else           return x + y;
  endfunction

  assign w_not_empty = (r_count != '0);
  assign w_not_full  = (r_count != c_FULL);
  assign w_do_start  = bus.EN_start && w_not_full;
  assign w_do_check  = bus.EN_check && w_not_empty;

  assign w_head   = r_mem[r_rd_ptr];
  assign w_head_f = f_comb(w_head[2*WIDTH-1:WIDTH], w_head[WIDTH-1:0]);

  // Gate on occupancy so stale/uninitialised storage never reaches the outputs.
  assign w_result = w_not_empty ? f_comb(w_head_f, bus.result_stc_1) : '0;
  assign w_check  = w_not_empty ? f_comb(r_acc, w_head_f ^ bus.check_std_1) : '0;

  assign bus.RDY_start  = w_not_full;
  assign bus.RDY_result = w_not_empty;
  assign bus.RDY_check  = w_not_empty;
  assign bus.result     = w_result;
  assign bus.check      = w_check;

  always_ff @(posedge CLK) begin
    if (w_do_start) r_mem[r_wr_ptr] <= {bus.start_sta_1, bus.start_stb_1};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_acc    <= '0;
    end else begin
      if (w_do_start) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_check) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_acc    <= w_check;
      end
      if (w_do_start && !w_do_check)      r_count <= r_count + 1'b1;
      else if (!w_do_start && w_do_check) r_count <= r_count - 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_param_method_queue.sv
// ============================================================================
// tb_param_method_queue : vector table + scoreboard bench for param_method_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_param_method_queue;
  logic CLK;
  logic RST_N;

  param_method_queue_if #(.WIDTH(11)) bus0 ();
  param_method_queue_if #(.WIDTH(11)) bus1 ();

  param_method_queue #(.WIDTH(11), .DEPTH(4), .MODE(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus0.slave)
  );
  param_method_queue #(.WIDTH(11), .DEPTH(4), .MODE(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        es;
    logic [10:0] sa;
    logic [10:0] sb;
    logic        ec;
    logic [10:0] sd;
    logic [10:0] sc;
    logic        rs;
    logic        rr;
    logic [10:0] res;
    logic [10:0] chk;
  } vec_t;

  vec_t        tbl[$];
  logic [21:0] sb_q[$];
  logic [10:0] sb_acc;
  int          n_applied;
  int          n_miss;

  function automatic vec_t mk(input logic rst, input logic es, input int sa, input int sb,
                              input logic ec, input int sd, input int sc,
                              input logic rs, input logic rr, input int res, input int chk);
    vec_t v;
    v.rst = rst; v.es = es; v.sa = sa[10:0]; v.sb = sb[10:0];
    v.ec = ec; v.sd = sd[10:0]; v.sc = sc[10:0];
    v.rs = rs; v.rr = rr; v.res = res[10:0]; v.chk = chk[10:0];
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [10:0] sb_exp;
    logic [10:0] head;
    string       tag;
    @(negedge CLK);
    bus0.EN_start     = v.es;
    bus0.start_sta_1  = v.sa;
    bus0.start_stb_1  = v.sb;
    bus0.EN_check     = v.ec;
    bus0.check_std_1  = v.sd;
    bus0.result_stc_1 = v.sc;
    if (v.rst) RST_N = 1'b0;
    #1;
    tag = $sformatf("v%0d", idx);
    cmp({tag, ".rdy_start"},  bus0.RDY_start,  v.rs);
    cmp({tag, ".rdy_result"}, bus0.RDY_result, v.rr);
    cmp({tag, ".rdy_check"},  bus0.RDY_check,  v.rr);
    cmp({tag, ".result"},     bus0.result,     v.res);
    cmp({tag, ".check"},      bus0.check,      v.chk);
    // independent model: head sum from pushed operands
    if (v.rst || sb_q.size() == 0) sb_exp = '0;
    else begin
      head   = sb_q[0][21:11] + sb_q[0][10:0];
      sb_exp = sb_acc + (head ^ v.sd);
    end
    cmp({tag, ".sb_check"}, bus0.check, sb_exp);
    if (v.rst) begin
      #1 RST_N = 1'b1;
      sb_q.delete();
      sb_acc = '0;
    end else begin
      logic full_pre;
      full_pre = (sb_q.size() == 4);
      if (v.ec && sb_q.size() != 0) begin
        sb_acc = sb_exp;
        void'(sb_q.pop_front());
      end
      if (v.es && !full_pre) sb_q.push_back({v.sa, v.sb});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    n_applied = 0;
    n_miss    = 0;
    sb_acc    = '0;
    RST_N     = 1'b0;
    {bus0.EN_start, bus0.EN_check, bus1.EN_start, bus1.EN_check} = '0;
    {bus0.start_sta_1, bus0.start_stb_1, bus0.check_std_1, bus0.result_stc_1} = '0;
    {bus1.start_sta_1, bus1.start_stb_1, bus1.check_std_1, bus1.result_stc_1} = '0;

    //           rst es sa   sb   ec sd sc    rs rr res  chk
    tbl.push_back(mk(1, 0, 0,    0,    0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 1, 5,    7,    0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 3,    1, 1, 15,   12));
    tbl.push_back(mk(0, 1, 0,    0,    0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 0,    12));
    tbl.push_back(mk(1, 0, 0,    0,    0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 1, 2047, 2047, 0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 2047, 1, 1, 2045, 2046));
    tbl.push_back(mk(0, 1, 0,    0,    0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 0,    2046));
    tbl.push_back(mk(1, 0, 0,    0,    0, 0, 0,    1, 0, 0,    0));
    // fill to DEPTH, overflow attempt, drain with wrap
    tbl.push_back(mk(0, 1, 1,    0,    0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 1, 2,    0,    0, 0, 0,    1, 1, 1,    1));
    tbl.push_back(mk(0, 1, 3,    0,    0, 0, 0,    1, 1, 1,    1));
    tbl.push_back(mk(0, 1, 4,    0,    0, 0, 0,    1, 1, 1,    1));
    tbl.push_back(mk(0, 1, 5,    0,    0, 0, 0,    0, 1, 1,    1));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    0, 1, 1,    1));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 2,    3));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 3,    6));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 4,    10));
    tbl.push_back(mk(0, 0, 0,    0,    0, 0, 0,    1, 0, 0,    0));
    // refill after wrap, full start+check, mid-level start+check
    tbl.push_back(mk(0, 1, 1,    1,    0, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 1, 2,    2,    0, 0, 0,    1, 1, 2,    12));
    tbl.push_back(mk(0, 1, 3,    3,    0, 0, 0,    1, 1, 2,    12));
    tbl.push_back(mk(0, 1, 4,    4,    0, 0, 0,    1, 1, 2,    12));
    tbl.push_back(mk(0, 1, 9,    9,    1, 0, 0,    0, 1, 2,    12));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 4,    16));
    tbl.push_back(mk(0, 1, 7,    0,    1, 0, 0,    1, 1, 6,    22));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 8,    30));
    tbl.push_back(mk(0, 0, 0,    0,    1, 5, 1,    1, 1, 8,    32));
    tbl.push_back(mk(0, 0, 0,    0,    0, 0, 0,    1, 0, 0,    0));
    // start+check on empty: no bypass
    tbl.push_back(mk(0, 1, 6,    6,    1, 0, 0,    1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 0,    0,    1, 0, 0,    1, 1, 12,   44));

    repeat (2) @(negedge CLK);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    @(negedge CLK);
    bus0.EN_start = 1'b0;
    bus0.EN_check = 1'b0;

    // MODE 1 (xor) instance
    @(negedge CLK);
    bus1.EN_start = 1'b1; bus1.start_sta_1 = 11'h155; bus1.start_stb_1 = 11'h0AA;
    #1 cmp("m1.empty_rdy_check", bus1.RDY_check, 1'b0);
    @(negedge CLK);
    bus1.EN_start = 1'b0; bus1.check_std_1 = 11'h7FF; bus1.result_stc_1 = 11'h000;
    #1 cmp("m1.result", bus1.result, 11'h1FF);
    cmp("m1.check_7ff", bus1.check, 11'h600);
    bus1.check_std_1 = 11'h1FF;
    #1 cmp("m1.check_1ff", bus1.check, 11'h000);
    bus1.EN_check = 1'b1;
    @(negedge CLK);
    bus1.EN_check = 1'b0;
    bus1.EN_start = 1'b1; bus1.start_sta_1 = 11'h00F; bus1.start_stb_1 = 11'h0F0;
    @(negedge CLK);
    bus1.EN_start = 1'b0; bus1.EN_check = 1'b1; bus1.check_std_1 = 11'h000;
    #1 cmp("m1.acc_check", bus1.check, 11'h0FF);
    @(negedge CLK);
    bus1.EN_check = 1'b0;
    bus1.EN_start = 1'b1; bus1.start_sta_1 = 11'h00F; bus1.start_stb_1 = 11'h000;
    @(negedge CLK);
    bus1.start_sta_1 = 11'h0F0;
    @(negedge CLK);
    bus1.EN_start = 1'b0;
    #1 cmp("m1.rdy_check_mid", bus1.RDY_check, 1'b1);
    cmp("m1.check_mid", bus1.check, 11'h0F0);
    // asynchronous reset mid-queue, no clock edge before sampling
    RST_N = 1'b0;
    #1 cmp("m1.rst_rdy_check", bus1.RDY_check, 1'b0);
    cmp("m1.rst_rdy_start", bus1.RDY_start, 1'b1);
    cmp("m1.rst_check", bus1.check, 11'h000);
    cmp("m1.rst_result", bus1.result, 11'h000);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    bus1.EN_start = 1'b1; bus1.start_sta_1 = 11'h001; bus1.start_stb_1 = 11'h002;
    @(negedge CLK);
    bus1.EN_start = 1'b0; bus1.check_std_1 = 11'h000;
    #1 cmp("m1.acc_cleared", bus1.check, 11'h003);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end
endmodule

`default_nettype wire
